// File: rtl/routing_table_lookup_engine.sv
`timescale 1ns/1ps
// routing_table_lookup_engine
// Parses the host and switch path table headers out of a fixed-latency word
// memory, checks magics and bounds, then serves tagged host/path lookups over
// a valid/ready request/response pair.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   mem_rd_en/mem_addr         1-cycle word read strobe and 4-aligned byte address
//   mem_rd_data                read word, valid MEM_LATENCY cycles after the strobe
//   start                      header parse request (pulse)
//   busy/tables_valid          activity and parse-OK status
//   parse_error/err_code       parse failure flag and cause (1 host magic, 2 path magic, 3 bounds)
//   host_count/max_switch_id   parsed header fields
//   q_*                        lookup request (type, host index or src/dst, tag)
//   r_*                        lookup response (tag, type, range error, raw entry words)
module routing_table_lookup_engine #(
   parameter int unsigned           MAX_HOSTS    = 64,
   parameter int unsigned           MAX_SWITCHES = 16,
   parameter int unsigned           ADDR_WIDTH   = 32,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = '0,
   parameter int unsigned           MEM_LATENCY  = 1,
   parameter int unsigned           TAG_W        = 4,
   parameter logic [31:0]           HOST_MAGIC   = 32'h484F5354,
   parameter logic [31:0]           PATH_MAGIC   = 32'h53574954,
   localparam int unsigned          HIDX_W       = $clog2(MAX_HOSTS),
   localparam int unsigned          SID_W        = $clog2(MAX_SWITCHES)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   output logic                  mem_rd_en,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic [31:0]           mem_rd_data,
   input  logic                  start,
   output logic                  busy,
   output logic                  tables_valid,
   output logic                  parse_error,
   output logic [1:0]            err_code,
   output logic [31:0]           host_count,
   output logic [31:0]           max_switch_id,
   input  logic                  q_valid,
   output logic                  q_ready,
   input  logic                  q_type,
   input  logic [HIDX_W-1:0]     q_index,
   input  logic [SID_W-1:0]      q_src,
   input  logic [SID_W-1:0]      q_dst,
   input  logic [TAG_W-1:0]      q_tag,
   output logic                  r_valid,
   input  logic                  r_ready,
   output logic [TAG_W-1:0]      r_tag,
   output logic                  r_type,
   output logic                  r_err,
   output logic [31:0]           r_w0,
   output logic [31:0]           r_w1,
   output logic [31:0]           r_w2,
   output logic [31:0]           r_w3,
   output logic [31:0]           r_w4,
   output logic [31:0]           r_w5
);

   localparam int unsigned LAT_W  = 3;
   localparam int unsigned WORD_W = 3;

   typedef enum logic [3:0] {
      IDLE, H_MAGIC, H_COUNT, P_MAGIC, P_SWCNT, P_MAXID, READY, Q_FETCH, Q_RESP, ERROR
   } state_t;

   state_t                state_q, state_d;
   logic [LAT_W-1:0]      wait_q, wait_d;
   logic [WORD_W-1:0]     word_q, word_d;
   logic [ADDR_WIDTH-1:0] path_base_q, path_base_d;
   logic [31:0]           rw_q [6];
   logic [31:0]           rw_d [6];

   logic                  mem_rd_en_d, busy_d, tables_valid_d, parse_error_d, q_ready_d;
   logic                  r_valid_d, r_type_d, r_err_d;
   logic [ADDR_WIDTH-1:0] mem_addr_d;
   logic [1:0]            err_code_d;
   logic [31:0]           host_count_d, max_switch_id_d;
   logic [TAG_W-1:0]      r_tag_d;

   logic                  sample;
   logic                  q_bad;
   logic [ADDR_WIDTH-1:0] q_addr;
   logic [ADDR_WIDTH-1:0] path_lin;

   // Query range check and entry address, evaluated on the live request fields.
   always_comb begin
      path_lin = ADDR_WIDTH'(q_src) * (ADDR_WIDTH'(max_switch_id) + ADDR_WIDTH'(1))
               + ADDR_WIDTH'(q_dst);
      if (q_type) begin
         q_bad  = (32'(q_src) > max_switch_id) || (32'(q_dst) > max_switch_id);
         q_addr = path_base_q + ADDR_WIDTH'(12) + (path_lin << 4);
      end else begin
         q_bad  = (32'(q_index) >= host_count);
         q_addr = BASE_ADDR + ADDR_WIDTH'(8) + ADDR_WIDTH'(24) * ADDR_WIDTH'(q_index);
      end
   end

   // Next-state and next-output logic; every read state issues its strobe on entry.
   always_comb begin
      state_d         = state_q;
      mem_rd_en_d     = 1'b0;
      mem_addr_d      = mem_addr;
      wait_d          = (wait_q != '0) ? wait_q - LAT_W'(1) : '0;
      word_d          = word_q;
      path_base_d     = path_base_q;
      tables_valid_d  = tables_valid;
      parse_error_d   = parse_error;
      err_code_d      = err_code;
      host_count_d    = host_count;
      max_switch_id_d = max_switch_id;
      r_valid_d       = r_valid;
      r_tag_d         = r_tag;
      r_type_d        = r_type;
      r_err_d         = r_err;
      rw_d            = rw_q;
      sample          = (wait_q == '0);

      unique case (state_q)
         IDLE, READY, ERROR: begin
            // A pending request wins over start so an accepted query is never lost.
            if (state_q == READY && q_ready && q_valid) begin
               r_type_d = q_type;
               r_tag_d  = q_tag;
               r_err_d  = 1'b0;
               word_d   = '0;
               for (int i = 0; i < 6; i++) rw_d[i] = '0;
               if (q_bad) begin
                  r_err_d   = 1'b1;
                  r_valid_d = 1'b1;
                  state_d   = Q_RESP;
               end else begin
                  state_d     = Q_FETCH;
                  mem_rd_en_d = 1'b1;
                  mem_addr_d  = q_addr;
                  wait_d      = LAT_W'(MEM_LATENCY);
               end
            end else if (start) begin
               tables_valid_d = 1'b0;
               parse_error_d  = 1'b0;
               err_code_d     = 2'd0;
               state_d        = H_MAGIC;
               mem_rd_en_d    = 1'b1;
               mem_addr_d     = BASE_ADDR;
               wait_d         = LAT_W'(MEM_LATENCY);
            end
         end
         H_MAGIC: if (sample) begin
            if (mem_rd_data != HOST_MAGIC) begin
               state_d       = ERROR;
               parse_error_d = 1'b1;
               err_code_d    = 2'd1;
            end else begin
               state_d     = H_COUNT;
               mem_rd_en_d = 1'b1;
               mem_addr_d  = BASE_ADDR + ADDR_WIDTH'(4);
               wait_d      = LAT_W'(MEM_LATENCY);
            end
         end
         H_COUNT: if (sample) begin
            host_count_d = mem_rd_data;
            if (mem_rd_data > 32'(MAX_HOSTS)) begin
               state_d       = ERROR;
               parse_error_d = 1'b1;
               err_code_d    = 2'd3;
            end else begin
               path_base_d = BASE_ADDR + ADDR_WIDTH'(8) + ADDR_WIDTH'(24) * ADDR_WIDTH'(mem_rd_data);
               state_d     = P_MAGIC;
               mem_rd_en_d = 1'b1;
               mem_addr_d  = path_base_d;
               wait_d      = LAT_W'(MEM_LATENCY);
            end
         end
         P_MAGIC: if (sample) begin
            if (mem_rd_data != PATH_MAGIC) begin
               state_d       = ERROR;
               parse_error_d = 1'b1;
               err_code_d    = 2'd2;
            end else begin
               state_d     = P_SWCNT;
               mem_rd_en_d = 1'b1;
               mem_addr_d  = path_base_q + ADDR_WIDTH'(4);
               wait_d      = LAT_W'(MEM_LATENCY);
            end
         end
         // switch_count is read to keep the header walk uniform; nothing depends on it.
         P_SWCNT: if (sample) begin
            state_d     = P_MAXID;
            mem_rd_en_d = 1'b1;
            mem_addr_d  = path_base_q + ADDR_WIDTH'(8);
            wait_d      = LAT_W'(MEM_LATENCY);
         end
         P_MAXID: if (sample) begin
            max_switch_id_d = mem_rd_data;
            if (mem_rd_data >= 32'(MAX_SWITCHES)) begin
               state_d       = ERROR;
               parse_error_d = 1'b1;
               err_code_d    = 2'd3;
            end else begin
               state_d        = READY;
               tables_valid_d = 1'b1;
            end
         end
         Q_FETCH: if (sample) begin
            rw_d[word_q] = mem_rd_data;
            if (word_q == (r_type ? WORD_W'(3) : WORD_W'(5))) begin
               state_d   = Q_RESP;
               r_valid_d = 1'b1;
            end else begin
               word_d      = word_q + WORD_W'(1);
               mem_rd_en_d = 1'b1;
               mem_addr_d  = mem_addr + ADDR_WIDTH'(4);
               wait_d      = LAT_W'(MEM_LATENCY);
            end
         end
         Q_RESP: if (r_ready) begin
            r_valid_d = 1'b0;
            state_d   = READY;
         end
         default: state_d = IDLE;
      endcase

      busy_d    = !(state_d inside {IDLE, READY, ERROR});
      q_ready_d = (state_d == READY) && !r_valid_d;
   end

   // State and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         wait_q        <= '0;
         word_q        <= '0;
         path_base_q   <= '0;
         mem_rd_en     <= 1'b0;
         mem_addr      <= '0;
         busy          <= 1'b0;
         tables_valid  <= 1'b0;
         parse_error   <= 1'b0;
         err_code      <= 2'd0;
         host_count    <= '0;
         max_switch_id <= '0;
         q_ready       <= 1'b0;
         r_valid       <= 1'b0;
         r_tag         <= '0;
         r_type        <= 1'b0;
         r_err         <= 1'b0;
         for (int i = 0; i < 6; i++) rw_q[i] <= '0;
      end else begin
         state_q       <= state_d;
         wait_q        <= wait_d;
         word_q        <= word_d;
         path_base_q   <= path_base_d;
         mem_rd_en     <= mem_rd_en_d;
         mem_addr      <= mem_addr_d;
         busy          <= busy_d;
         tables_valid  <= tables_valid_d;
         parse_error   <= parse_error_d;
         err_code      <= err_code_d;
         host_count    <= host_count_d;
         max_switch_id <= max_switch_id_d;
         q_ready       <= q_ready_d;
         r_valid       <= r_valid_d;
         r_tag         <= r_tag_d;
         r_type        <= r_type_d;
         r_err         <= r_err_d;
         for (int i = 0; i < 6; i++) rw_q[i] <= rw_d[i];
      end
   end

   assign r_w0 = rw_q[0];
   assign r_w1 = rw_q[1];
   assign r_w2 = rw_q[2];
   assign r_w3 = rw_q[3];
   assign r_w4 = rw_q[4];
   assign r_w5 = rw_q[5];

endmodule

// File: tb/tb_routing_table_lookup_engine.sv
`timescale 1ns/1ps
// Directed bench: instance "a" uses MEM_LATENCY=1, instance "b" MEM_LATENCY=3.
module tb_routing_table_lookup_engine;

   localparam logic [31:0] HM = 32'h484F5354;
   localparam logic [31:0] PM = 32'h53574954;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int lat;

   logic [31:0] mem [0:255];

   // shared request payload
   logic       q_type;
   logic [5:0] q_index;
   logic [3:0] q_src, q_dst, q_tag;

   // instance a signals
   logic        mem_rd_en_a, start_a, busy_a, tables_valid_a, parse_error_a, q_valid_a, q_ready_a;
   logic        r_valid_a, r_ready_a, r_type_a, r_err_a;
   logic [31:0] mem_addr_a, mem_rd_data_a, host_count_a, max_switch_id_a;
   logic [1:0]  err_code_a;
   logic [3:0]  r_tag_a;
   logic [31:0] r_w0_a, r_w1_a, r_w2_a, r_w3_a, r_w4_a, r_w5_a;

   // instance b signals
   logic        mem_rd_en_b, start_b, busy_b, tables_valid_b, parse_error_b, q_valid_b, q_ready_b;
   logic        r_valid_b, r_ready_b, r_type_b, r_err_b;
   logic [31:0] mem_addr_b, mem_rd_data_b, host_count_b, max_switch_id_b;
   logic [1:0]  err_code_b;
   logic [3:0]  r_tag_b;
   logic [31:0] r_w0_b, r_w1_b, r_w2_b, r_w3_b, r_w4_b, r_w5_b;

   routing_table_lookup_engine #(.MEM_LATENCY(1)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .mem_rd_en(mem_rd_en_a), .mem_addr(mem_addr_a),
      .mem_rd_data(mem_rd_data_a), .start(start_a), .busy(busy_a), .tables_valid(tables_valid_a),
      .parse_error(parse_error_a), .err_code(err_code_a), .host_count(host_count_a),
      .max_switch_id(max_switch_id_a), .q_valid(q_valid_a), .q_ready(q_ready_a), .q_type(q_type),
      .q_index(q_index), .q_src(q_src), .q_dst(q_dst), .q_tag(q_tag), .r_valid(r_valid_a),
      .r_ready(r_ready_a), .r_tag(r_tag_a), .r_type(r_type_a), .r_err(r_err_a),
      .r_w0(r_w0_a), .r_w1(r_w1_a), .r_w2(r_w2_a), .r_w3(r_w3_a), .r_w4(r_w4_a), .r_w5(r_w5_a));

   routing_table_lookup_engine #(.MEM_LATENCY(3)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .mem_rd_en(mem_rd_en_b), .mem_addr(mem_addr_b),
      .mem_rd_data(mem_rd_data_b), .start(start_b), .busy(busy_b), .tables_valid(tables_valid_b),
      .parse_error(parse_error_b), .err_code(err_code_b), .host_count(host_count_b),
      .max_switch_id(max_switch_id_b), .q_valid(q_valid_b), .q_ready(q_ready_b), .q_type(q_type),
      .q_index(q_index), .q_src(q_src), .q_dst(q_dst), .q_tag(q_tag), .r_valid(r_valid_b),
      .r_ready(r_ready_b), .r_tag(r_tag_b), .r_type(r_type_b), .r_err(r_err_b),
      .r_w0(r_w0_b), .r_w1(r_w1_b), .r_w2(r_w2_b), .r_w3(r_w3_b), .r_w4(r_w4_b), .r_w5(r_w5_b));

   // Memory models: data valid exactly MEM_LATENCY cycles after the strobe cycle.
   logic        da_v = 1'b0;
   logic [31:0] da_a = '0;
   logic        db_v [3] = '{1'b0, 1'b0, 1'b0};
   logic [31:0] db_a [3];
   always @(posedge clk) begin
      da_v  <= mem_rd_en_a;
      da_a  <= mem_addr_a;
      db_v[0] <= mem_rd_en_b; db_a[0] <= mem_addr_b;
      db_v[1] <= db_v[0];     db_a[1] <= db_a[0];
      db_v[2] <= db_v[1];     db_a[2] <= db_a[1];
   end
   assign mem_rd_data_a = da_v    ? mem[da_a[9:2]]    : 32'hBAD0BAD0;
   assign mem_rd_data_b = db_v[2] ? mem[db_a[2][9:2]] : 32'hBAD0BAD0;

   // Read address logs
   logic [31:0] alog_a [$];
   logic [31:0] alog_b [$];
   always @(posedge clk) begin
      if (mem_rd_en_a === 1'b1) alog_a.push_back(mem_addr_a);
      if (mem_rd_en_b === 1'b1) alog_b.push_back(mem_addr_b);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic parse_a();
      int n;
      alog_a.delete();
      @(negedge clk) start_a = 1'b1;
      @(negedge clk) start_a = 1'b0;
      n = 0;
      while (busy_a && n < 200) begin @(negedge clk); n++; end
      chk("parse_a_timeout", 32'(n < 200), 32'd1);
   endtask

   task automatic send_a(input logic t, input logic [5:0] idx, input logic [3:0] s,
                         input logic [3:0] d, input logic [3:0] tag);
      int n;
      @(negedge clk);
      q_type = t; q_index = idx; q_src = s; q_dst = d; q_tag = tag; q_valid_a = 1'b1;
      n = 0;
      while (!q_ready_a && n < 50) begin @(negedge clk); n++; end
      chk("q_ready_a", 32'(q_ready_a), 32'd1);
      @(posedge clk); #1 q_valid_a = 1'b0;
   endtask

   task automatic wait_r_a(output int l);
      l = 0;
      while (!r_valid_a && l < 100) begin @(posedge clk); #1; l++; end
   endtask

   task automatic ack_a();
      @(negedge clk) r_ready_a = 1'b1;
      @(posedge clk); #1 r_ready_a = 1'b0;
      chk("r_valid_a_drop", 32'(r_valid_a), 32'd0);
      chk("q_ready_a_back", 32'(q_ready_a), 32'd1);
   endtask

   initial begin
      int n, seen;
      logic [31:0] exp_parse [5];
      exp_parse = '{32'd0, 32'd4, 32'd80, 32'd84, 32'd88};

      for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE0000 | 32'(i);
      mem[0] = HM;  mem[1] = 32'd3;
      // host 1 at byte 32
      mem[8]  = 32'h0A000002; mem[9]  = 32'd1;        mem[10] = 32'h0A0000F1;
      mem[11] = 32'h00120003; mem[12] = 32'h22334455; mem[13] = 32'h00000011;
      // path header at byte 80
      mem[20] = PM; mem[21] = 32'd3; mem[22] = 32'd2;
      // path entry src=2,dst=1 at byte 80+12+16*7 = 204
      mem[51] = 32'h00050101; mem[52] = 32'h00070002; mem[53] = 32'h0A0000F2; mem[54] = 32'h00080004;

      start_a = 0; q_valid_a = 0; r_ready_a = 0;
      start_b = 0; q_valid_b = 0; r_ready_b = 0;
      q_type = 0; q_index = 0; q_src = 0; q_dst = 0; q_tag = 0;

      // reset state
      repeat (3) @(negedge clk);
      chk("rst_busy", 32'(busy_a), 32'd0);
      chk("rst_tables_valid", 32'(tables_valid_a), 32'd0);
      chk("rst_parse_error", 32'(parse_error_a), 32'd0);
      chk("rst_mem_rd_en", 32'(mem_rd_en_a), 32'd0);
      chk("rst_q_ready", 32'(q_ready_a), 32'd0);
      chk("rst_r_valid", 32'(r_valid_a), 32'd0);
      @(negedge clk) rst_n = 1'b1;

      // valid parse, latency 1
      parse_a();
      chk("p1_tables_valid", 32'(tables_valid_a), 32'd1);
      chk("p1_parse_error", 32'(parse_error_a), 32'd0);
      chk("p1_err_code", 32'(err_code_a), 32'd0);
      chk("p1_host_count", host_count_a, 32'd3);
      chk("p1_max_switch_id", max_switch_id_a, 32'd2);
      chk("p1_q_ready", 32'(q_ready_a), 32'd1);
      chk("p1_nreads", 32'(alog_a.size()), 32'd5);
      for (int i = 0; i < 5; i++)
         if (i < alog_a.size()) chk("p1_addr", alog_a[i], exp_parse[i]);

      // bad host magic
      mem[0] = 32'hDEADBEEF;
      parse_a();
      repeat (5) @(negedge clk);
      chk("p2_parse_error", 32'(parse_error_a), 32'd1);
      chk("p2_err_code", 32'(err_code_a), 32'd1);
      chk("p2_tables_valid", 32'(tables_valid_a), 32'd0);
      chk("p2_nreads", 32'(alog_a.size()), 32'd1);
      mem[0] = HM;
      parse_a();
      chk("p3_tables_valid", 32'(tables_valid_a), 32'd1);
      chk("p3_parse_error", 32'(parse_error_a), 32'd0);

      // host query index 1, tag 5: six reads of 2 cycles each
      alog_a.delete();
      send_a(1'b0, 6'd1, 4'd0, 4'd0, 4'd5);
      wait_r_a(lat);
      chk("h_latency", 32'(lat), 32'd12);
      chk("h_r_tag", 32'(r_tag_a), 32'd5);
      chk("h_r_err", 32'(r_err_a), 32'd0);
      chk("h_r_type", 32'(r_type_a), 32'd0);
      chk("h_w0", r_w0_a, 32'h0A000002);
      chk("h_w1", r_w1_a, 32'd1);
      chk("h_w2", r_w2_a, 32'h0A0000F1);
      chk("h_w3", r_w3_a, 32'h00120003);
      chk("h_mac_lo", r_w4_a, 32'h22334455);
      chk("h_mac_hi", r_w5_a, 32'h00000011);
      chk("h_nreads", 32'(alog_a.size()), 32'd6);
      for (int i = 0; i < 6; i++)
         if (i < alog_a.size()) chk("h_addr", alog_a[i], 32'd32 + 32'(4 * i));
      ack_a();

      // out-of-range host index and path src
      alog_a.delete();
      send_a(1'b0, 6'd3, 4'd0, 4'd0, 4'd9);
      wait_r_a(lat);
      chk("eh_latency", 32'(lat), 32'd0);
      chk("eh_r_err", 32'(r_err_a), 32'd1);
      chk("eh_r_tag", 32'(r_tag_a), 32'd9);
      chk("eh_w0", r_w0_a, 32'd0);
      chk("eh_w4", r_w4_a, 32'd0);
      ack_a();
      send_a(1'b1, 6'd0, 4'd3, 4'd0, 4'd2);
      wait_r_a(lat);
      chk("ep_latency", 32'(lat), 32'd0);
      chk("ep_r_err", 32'(r_err_a), 32'd1);
      chk("ep_r_type", 32'(r_type_a), 32'd1);
      ack_a();
      chk("e_nreads", 32'(alog_a.size()), 32'd0);

      // instance b: parse then path query src=2,dst=1 with latency 3
      @(negedge clk) start_b = 1'b1;
      @(negedge clk) start_b = 1'b0;
      n = 0;
      while (busy_b && n < 200) begin @(negedge clk); n++; end
      chk("b_tables_valid", 32'(tables_valid_b), 32'd1);
      chk("b_host_count", host_count_b, 32'd3);
      chk("b_max_switch_id", max_switch_id_b, 32'd2);
      chk("b_parse_error", 32'({parse_error_b, err_code_b}), 32'd0);
      alog_b.delete();
      @(negedge clk);
      q_type = 1'b1; q_index = 6'd0; q_src = 4'd2; q_dst = 4'd1; q_tag = 4'hA; q_valid_b = 1'b1;
      n = 0;
      while (!q_ready_b && n < 50) begin @(negedge clk); n++; end
      chk("q_ready_b", 32'(q_ready_b), 32'd1);
      @(posedge clk); #1 q_valid_b = 1'b0;
      lat = 0;
      while (!r_valid_b && lat < 100) begin @(posedge clk); #1; lat++; end
      chk("p_latency", 32'(lat), 32'd16);
      chk("p_nreads", 32'(alog_b.size()), 32'd4);
      for (int i = 0; i < 4; i++)
         if (i < alog_b.size()) chk("p_addr", alog_b[i], 32'd204 + 32'(4 * i));
      chk("p_valid_bit", 32'(r_w0_b[0]), 32'd1);
      chk("p_w1", r_w1_b, 32'h00070002);
      chk("p_w3", r_w3_b, 32'h00080004);
      chk("p_w4", r_w4_b, 32'd0);
      chk("p_w5", r_w5_b, 32'd0);
      chk("p_meta", 32'({r_type_b, r_err_b, r_tag_b}), 32'h2A);
      repeat (10) begin
         @(posedge clk); #1;
         chk("hold_r_valid", 32'(r_valid_b), 32'd1);
         chk("hold_w0", r_w0_b, 32'h00050101);
         chk("hold_w2", r_w2_b, 32'h0A0000F2);
         chk("hold_q_ready", 32'(q_ready_b), 32'd0);
      end
      @(negedge clk) r_ready_b = 1'b1;
      @(posedge clk); #1 r_ready_b = 1'b0;
      chk("b_r_valid_drop", 32'(r_valid_b), 32'd0);
      chk("b_q_ready_back", 32'(q_ready_b), 32'd1);

      // reset during the third word of a host fetch
      send_a(1'b0, 6'd2, 4'd0, 4'd0, 4'd3);
      seen = 0; n = 0;
      forever begin
         if (mem_rd_en_a) seen++;
         if (seen == 3 || n >= 60) break;
         @(posedge clk); #1; n++;
      end
      chk("rst_third_strobe", 32'(seen), 32'd3);
      rst_n = 1'b0;
      #1;
      chk("mid_mem_rd_en", 32'(mem_rd_en_a), 32'd0);
      chk("mid_mem_addr", mem_addr_a, 32'd0);
      chk("mid_busy", 32'(busy_a), 32'd0);
      chk("mid_tables_valid", 32'(tables_valid_a), 32'd0);
      chk("mid_host_count", host_count_a, 32'd0);
      chk("mid_max_switch_id", max_switch_id_a, 32'd0);
      chk("mid_r_tag", 32'(r_tag_a), 32'd0);
      chk("mid_w0", r_w0_a, 32'd0);
      chk("mid_w1", r_w1_a, 32'd0);
      @(negedge clk) rst_n = 1'b1;
      parse_a();
      chk("post_tables_valid", 32'(tables_valid_a), 32'd1);
      chk("post_host_count", host_count_a, 32'd3);
      chk("post_nreads", 32'(alog_a.size()), 32'd5);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
